// File: rtl/control_unit.sv
// Hardwired Mini-SRC control sequencer: fetch T0-T2, an opcode-specific T3-T7 sequence, then back to T0.
// Outputs are a Moore decode of the registered step and the opcode latched on entry to T3.
module control_unit #(
    parameter int MEM_WAIT = 0
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_ff,
    input  logic        Stop,
    output logic        IncPC,
    output logic        PC_enable,
    output logic        PCout,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        MDR_read,
    output logic        MDRout,
    output logic        IR_enable,
    output logic        RAM_write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        R_in,
    output logic        R_out,
    output logic        BAout,
    output logic        Cout,
    output logic        Y_enable,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        OutPort_enable,
    output logic        CON_enable,
    output logic [4:0]  alu_op,
    output logic        Run
);

    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} step_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000, OP_HALT = 5'b11010;
    localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT);

    step_t      state, state_next, end_target;
    logic [4:0] opcode;
    logic [1:0] wait_cnt, wait_cnt_next;
    logic       active;
    logic       stop_req;
    logic       mem_done;
    logic       ir_unused;

    assign ir_unused = ^IR[26:0];
    assign mem_done  = (wait_cnt == WAIT_LAST);
    // A Stop pulse seen at any edge is held until the current instruction finishes.
    assign end_target = (Stop || stop_req) ? HALT : T0;

    function automatic logic has_steps(input logic [4:0] op);
        case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_MUL, OP_DIV,
            OP_BR, OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_HALT: has_steps = 1'b1;
            default:                                                 has_steps = 1'b0;
        endcase
    endfunction

    function automatic logic is_last(input logic [4:0] op, input step_t st);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: is_last = (st == T5);
            OP_LD, OP_ST:                                   is_last = (st == T7);
            OP_MUL, OP_DIV, OP_BR:                          is_last = (st == T6);
            default:                                        is_last = (st == T3);
        endcase
    endfunction

    // active stays low until the first edge after Clear releases, so reset shows all-zero outputs.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state    <= T0;
            wait_cnt <= 2'd0;
            opcode   <= 5'd0;
            active   <= 1'b0;
            stop_req <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            active   <= 1'b1;
            if (Stop && active)
                stop_req <= 1'b1;
            if (state == T2 && state_next == T3)
                opcode <= IR[31:27];
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = 2'd0;
        if (!active) begin
            state_next = T0;
        end else begin
            case (state)
                T0: state_next = T1;
                T1: begin
                    if (mem_done) state_next = T2;
                    else          wait_cnt_next = wait_cnt + 2'd1;
                end
                T2: state_next = has_steps(IR[31:27]) ? T3 : end_target;
                T3, T4, T5, T6, T7: begin
                    if (opcode == OP_HALT)
                        state_next = HALT;
                    else if (state == T6 && opcode == OP_LD && !mem_done)
                        wait_cnt_next = wait_cnt + 2'd1;
                    else if (is_last(opcode, state))
                        state_next = end_target;
                    else begin
                        case (state)
                            T3:      state_next = T4;
                            T4:      state_next = T5;
                            T5:      state_next = T6;
                            default: state_next = T7;
                        endcase
                    end
                end
                default: state_next = HALT;
            endcase
        end
    end

    // T0 drives the ALU in increment mode via IncPC, so alu_op stays 0 there.
    always_comb begin
        IncPC = 1'b0; PC_enable = 1'b0; PCout = 1'b0; MAR_enable = 1'b0; MDR_enable = 1'b0;
        MDR_read = 1'b0; MDRout = 1'b0; IR_enable = 1'b0; RAM_write = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R_in = 1'b0; R_out = 1'b0; BAout = 1'b0; Cout = 1'b0;
        Y_enable = 1'b0; ZLowIn = 1'b0; ZHighIn = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0;
        HI_enable = 1'b0; LO_enable = 1'b0; HIout = 1'b0; LOout = 1'b0;
        InPortout = 1'b0; OutPort_enable = 1'b0; CON_enable = 1'b0;
        alu_op = 5'd0;
        Run    = active && (state != HALT);
        if (active) begin
            case (state)
                T0: begin PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
                T1: begin MDR_read = 1'b1; MDR_enable = 1'b1; ZLowout = 1'b1; PC_enable = mem_done; end
                T2: begin MDRout = 1'b1; IR_enable = 1'b1; end
                T3: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
                                  begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
                        OP_LDI, OP_LD, OP_ST:
                                  begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
                        OP_MUL, OP_DIV:
                                  begin Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
                        OP_BR:    begin Gra = 1'b1; R_out = 1'b1; CON_enable = 1'b1; end
                        OP_JR:    begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
                        OP_IN:    begin Gra = 1'b1; R_in = 1'b1; InPortout = 1'b1; end
                        OP_OUT:   begin Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1; end
                        OP_MFHI:  begin Gra = 1'b1; R_in = 1'b1; HIout = 1'b1; end
                        OP_MFLO:  begin Gra = 1'b1; R_in = 1'b1; LOout = 1'b1; end
                        default: ;
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR:
                            begin Grc = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; alu_op = opcode; end
                        OP_ADDI, OP_LDI, OP_LD, OP_ST:
                            begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = OP_ADD; end
                        OP_MUL, OP_DIV:
                            begin Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; alu_op = opcode; end
                        OP_BR:
                            begin PCout = 1'b1; Y_enable = 1'b1; end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI:
                                        begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                        OP_LD, OP_ST:   begin ZLowout = 1'b1; MAR_enable = 1'b1; end
                        OP_MUL, OP_DIV: begin ZLowout = 1'b1; LO_enable = 1'b1; end
                        OP_BR:          begin Cout = 1'b1; ZLowIn = 1'b1; alu_op = OP_ADD; end
                        default: ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_LD:          begin MDR_read = 1'b1; MDR_enable = 1'b1; end
                        OP_ST:          begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; end
                        OP_MUL, OP_DIV: begin ZHighout = 1'b1; HI_enable = 1'b1; end
                        OP_BR:          begin ZLowout = 1'b1; PC_enable = CON_ff; end
                        default: ;
                    endcase
                end
                T7: begin
                    case (opcode)
                        OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                        OP_ST:   RAM_write = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle control vectors expected from the step tables
// are queued when an instruction is applied and compared as the sequencer steps through it.
module tb_control_unit;

    localparam logic [27:0] INCPC  = 28'h1 << 0,  PC_EN   = 28'h1 << 1,  PCOUT   = 28'h1 << 2;
    localparam logic [27:0] MAR_EN = 28'h1 << 3,  MDR_EN  = 28'h1 << 4,  MDR_RD  = 28'h1 << 5;
    localparam logic [27:0] MDROUT = 28'h1 << 6,  IR_EN   = 28'h1 << 7,  RAM_WR  = 28'h1 << 8;
    localparam logic [27:0] GRA    = 28'h1 << 9,  GRB     = 28'h1 << 10, GRC     = 28'h1 << 11;
    localparam logic [27:0] R_IN   = 28'h1 << 12, R_OUT   = 28'h1 << 13, BAOUT   = 28'h1 << 14;
    localparam logic [27:0] COUT   = 28'h1 << 15, Y_EN    = 28'h1 << 16, ZLOWIN  = 28'h1 << 17;
    localparam logic [27:0] ZHIIN  = 28'h1 << 18, ZLOWOUT = 28'h1 << 19, ZHIOUT  = 28'h1 << 20;
    localparam logic [27:0] HI_EN  = 28'h1 << 21, LO_EN   = 28'h1 << 22, HIOUT   = 28'h1 << 23;
    localparam logic [27:0] LOOUT  = 28'h1 << 24, INPOUT  = 28'h1 << 25, OUTP_EN = 28'h1 << 26;
    localparam logic [27:0] CON_EN = 28'h1 << 27;
    localparam logic [4:0]  ALU_ADD = 5'b00011;

    logic        Clock, Clear, CON_ff, Stop;
    logic [31:0] IR;
    wire  [27:0] sa, sb;
    wire  [4:0]  alu_a, alu_b;
    wire         run_a, run_b;
    logic [33:0] va, vb;
    logic [33:0] exp_q[$];
    int          checks = 0, errors = 0;
    int          ram_cnt_a = 0, pc_cnt_b = 0;

    assign va = {run_a, alu_a, sa};
    assign vb = {run_b, alu_b, sb};

    control_unit #(.MEM_WAIT(0)) dut_a (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_ff(CON_ff), .Stop(Stop),
        .IncPC(sa[0]), .PC_enable(sa[1]), .PCout(sa[2]), .MAR_enable(sa[3]), .MDR_enable(sa[4]),
        .MDR_read(sa[5]), .MDRout(sa[6]), .IR_enable(sa[7]), .RAM_write(sa[8]),
        .Gra(sa[9]), .Grb(sa[10]), .Grc(sa[11]), .R_in(sa[12]), .R_out(sa[13]), .BAout(sa[14]),
        .Cout(sa[15]), .Y_enable(sa[16]), .ZLowIn(sa[17]), .ZHighIn(sa[18]), .ZLowout(sa[19]),
        .ZHighout(sa[20]), .HI_enable(sa[21]), .LO_enable(sa[22]), .HIout(sa[23]), .LOout(sa[24]),
        .InPortout(sa[25]), .OutPort_enable(sa[26]), .CON_enable(sa[27]),
        .alu_op(alu_a), .Run(run_a)
    );

    control_unit #(.MEM_WAIT(2)) dut_b (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_ff(CON_ff), .Stop(Stop),
        .IncPC(sb[0]), .PC_enable(sb[1]), .PCout(sb[2]), .MAR_enable(sb[3]), .MDR_enable(sb[4]),
        .MDR_read(sb[5]), .MDRout(sb[6]), .IR_enable(sb[7]), .RAM_write(sb[8]),
        .Gra(sb[9]), .Grb(sb[10]), .Grc(sb[11]), .R_in(sb[12]), .R_out(sb[13]), .BAout(sb[14]),
        .Cout(sb[15]), .Y_enable(sb[16]), .ZLowIn(sb[17]), .ZHighIn(sb[18]), .ZLowout(sb[19]),
        .ZHighout(sb[20]), .HI_enable(sb[21]), .LO_enable(sb[22]), .HIout(sb[23]), .LOout(sb[24]),
        .InPortout(sb[25]), .OutPort_enable(sb[26]), .CON_enable(sb[27]),
        .alu_op(alu_b), .Run(run_b)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] step(input logic [4:0] alu, input logic [27:0] s);
        return {1'b1, alu, s};
    endfunction

    task automatic checkInvariants(input string name, input logic [27:0] s);
        logic [9:0] outs;
        outs = {s[2], s[6], s[13], s[14], s[15], s[19], s[20], s[23], s[24], s[25]};
        if (s[9] | s[10] | s[11])
            checkOutput({name, "_gr_sel"}, 34'($countones({s[12], s[13], s[14]})), 34'd1);
        checkOutput({name, "_out_excl"}, 34'($countones(outs) <= 1), 34'd1);
    endtask

    initial begin
        forever begin
            @(negedge Clock);
            checkInvariants("a", sa);
            checkInvariants("b", sb);
            ram_cnt_a = ram_cnt_a + int'(sa[8]);
            pc_cnt_b  = pc_cnt_b + int'(sb[1]);
        end
    end

    // Queue the full cycle-by-cycle expectation for one instruction plus the step that follows it.
    task automatic applyStimulus(input logic [31:0] ir, input bit con, input int w, input bit stop_end);
        logic [4:0] op;
        IR     = ir;
        CON_ff = con;
        op     = ir[31:27];
        exp_q.push_back(step(5'd0, PCOUT | MAR_EN | INCPC | ZLOWIN));
        for (int i = 0; i <= w; i++)
            exp_q.push_back(step(5'd0, MDR_RD | MDR_EN | ZLOWOUT | ((i == w) ? PC_EN : 28'h0)));
        exp_q.push_back(step(5'd0, MDROUT | IR_EN));
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                exp_q.push_back(step(5'd0, GRB | R_OUT | Y_EN));
                exp_q.push_back(step(op, GRC | R_OUT | ZLOWIN));
                exp_q.push_back(step(5'd0, ZLOWOUT | GRA | R_IN));
            end
            5'b01100, 5'b00001: begin
                exp_q.push_back(step(5'd0, GRB | ((op == 5'b01100) ? R_OUT : BAOUT) | Y_EN));
                exp_q.push_back(step(ALU_ADD, COUT | ZLOWIN));
                exp_q.push_back(step(5'd0, ZLOWOUT | GRA | R_IN));
            end
            5'b00000, 5'b00010: begin
                exp_q.push_back(step(5'd0, GRB | BAOUT | Y_EN));
                exp_q.push_back(step(ALU_ADD, COUT | ZLOWIN));
                exp_q.push_back(step(5'd0, ZLOWOUT | MAR_EN));
                if (op == 5'b00000) begin
                    for (int i = 0; i <= w; i++)
                        exp_q.push_back(step(5'd0, MDR_RD | MDR_EN));
                    exp_q.push_back(step(5'd0, MDROUT | GRA | R_IN));
                end else begin
                    exp_q.push_back(step(5'd0, GRA | R_OUT | MDR_EN));
                    exp_q.push_back(step(5'd0, RAM_WR));
                end
            end
            5'b01111, 5'b10000: begin
                exp_q.push_back(step(5'd0, GRA | R_OUT | Y_EN));
                exp_q.push_back(step(op, GRB | R_OUT | ZLOWIN | ZHIIN));
                exp_q.push_back(step(5'd0, ZLOWOUT | LO_EN));
                exp_q.push_back(step(5'd0, ZHIOUT | HI_EN));
            end
            5'b10011: begin
                exp_q.push_back(step(5'd0, GRA | R_OUT | CON_EN));
                exp_q.push_back(step(5'd0, PCOUT | Y_EN));
                exp_q.push_back(step(ALU_ADD, COUT | ZLOWIN));
                exp_q.push_back(step(5'd0, ZLOWOUT | (con ? PC_EN : 28'h0)));
            end
            5'b10100: exp_q.push_back(step(5'd0, GRA | R_OUT | PC_EN));
            5'b10101: exp_q.push_back(step(5'd0, GRA | R_IN | INPOUT));
            5'b10110: exp_q.push_back(step(5'd0, GRA | R_OUT | OUTP_EN));
            5'b10111: exp_q.push_back(step(5'd0, GRA | R_IN | HIOUT));
            5'b11000: exp_q.push_back(step(5'd0, GRA | R_IN | LOOUT));
            5'b11010: exp_q.push_back(step(5'd0, 28'h0));
            default: ;
        endcase
        if (op == 5'b11010 || stop_end) begin
            exp_q.push_back(34'h0);
            exp_q.push_back(34'h0);
        end else begin
            exp_q.push_back(step(5'd0, PCOUT | MAR_EN | INCPC | ZLOWIN));
        end
    endtask

    task automatic doReset(input string name);
        Clear = 1'b0;
        Stop  = 1'b0;
        exp_q.delete();
        #3;
        checkOutput({name, "_reset_a"}, va, 34'h0);
        checkOutput({name, "_reset_b"}, vb, 34'h0);
        @(negedge Clock);
        Clear = 1'b1;
    endtask

    task automatic drain(input int n, input bit sel, input string name);
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            @(posedge Clock);
            #1;
            checkOutput($sformatf("%s_c%0d", name, i), sel ? vb : va, exp_q.pop_front());
        end
    endtask

    logic [31:0] prog [15] = '{32'hB9000000, 32'h18918000, 32'h20000000, 32'h28000000,
                               32'h30000000, 32'h60000000, 32'h08000000, 32'h80000000,
                               32'hA0000000, 32'hA8000000, 32'hB0000000, 32'hC0000000,
                               32'hC8000000, 32'hF8000000, 32'hD0000000};

    initial begin
        int pc_before, ram_before;
        Clear = 1'b0; Stop = 1'b0; IR = 32'h0; CON_ff = 1'b0;

        foreach (prog[i]) begin
            doReset($sformatf("op%08h", prog[i]));
            applyStimulus(prog[i], 1'b0, 0, 1'b0);
            drain(64, 1'b0, $sformatf("op%08h", prog[i]));
        end

        for (int c = 0; c < 2; c++) begin
            doReset($sformatf("br%0d", c));
            applyStimulus(32'h98000000, c[0], 0, 1'b0);
            drain(64, 1'b0, $sformatf("br%0d", c));
        end

        doReset("ld");
        pc_before = pc_cnt_b;
        applyStimulus(32'h00400000, 1'b0, 2, 1'b0);
        drain(64, 1'b1, "ld_w2");
        checkOutput("ld_pc_en_count", 34'(pc_cnt_b - pc_before), 34'd1);

        doReset("st");
        ram_before = ram_cnt_a;
        applyStimulus(32'h10000000, 1'b0, 0, 1'b0);
        drain(6, 1'b0, "st");
        #1 Clear = 1'b0;
        #1;
        checkOutput("st_async_clear_a", va, 34'h0);
        checkOutput("st_async_clear_b", vb, 34'h0);
        exp_q.delete();
        repeat (2) @(negedge Clock);
        Clear = 1'b1;
        applyStimulus(32'h10000000, 1'b0, 0, 1'b0);
        drain(3, 1'b0, "st_refetch");
        checkOutput("st_no_ram_write", 34'(ram_cnt_a - ram_before), 34'd0);

        doReset("mul_stop");
        applyStimulus(32'h78000000, 1'b0, 0, 1'b1);
        drain(5, 1'b0, "mul_stop_a");
        Stop = 1'b1;
        drain(1, 1'b0, "mul_stop_b");
        Stop = 1'b0;
        drain(64, 1'b0, "mul_stop_c");
        repeat (3) begin
            @(posedge Clock);
            #1;
            checkOutput("mul_halt_hold", va, 34'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
